// File: rtl/sia_pkg.sv
// Shared widths, dispatcher state encoding and nonce slicing helper
// for the Sia multi-core work dispatcher.
package sia_pkg;

  localparam int WORK_W   = 640;
  localparam int TARGET_W = 64;
  localparam int NONCE_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_RUN,
    ST_FLUSH
  } dispatch_state_t;

  // First nonce of slice i when the 32-bit space is cut into n equal parts
  function automatic logic [NONCE_W-1:0] slice_base(input int i, input int n);
    int lg;
    logic [63:0] v;
    lg = 0;
    for (int k = 0; k < 5; k++) begin
      if (n > (1 << k)) lg = k + 1;
    end
    v = 64'(unsigned'(i)) << (NONCE_W - lg);
    return v[NONCE_W-1:0];
  endfunction

endpackage

// File: rtl/sia_res_fifo.sv
// Synchronous result FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sia_res_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          wr;
  logic          rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

endmodule

// File: rtl/sia_dispatch.sv
// Sia multi-core work dispatcher: slices the nonce space, collects finds.
// Optional busy-cycle counter on hash_cnt with SIA_DISPATCH_HASHCNT_EN.
module sia_dispatch
  import sia_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int RES_DEPTH     = 4,
  parameter int STOP_ON_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     work_valid,
  output logic                     work_ready,
  input  logic [WORK_W-1:0]        work_data,
  input  logic [TARGET_W-1:0]      work_target,
  output logic [WORK_W-1:0]        core_work,
  output logic [TARGET_W-1:0]      core_target,
  output logic [NUM_CORES-1:0]     core_start,
  output logic [NUM_CORES*32-1:0]  core_nonce0,
  output logic [NUM_CORES-1:0]     core_abort,
  input  logic [NUM_CORES-1:0]     core_found,
  input  logic [NUM_CORES*32-1:0]  core_nonce,
  input  logic [NUM_CORES-1:0]     core_done,
  input  logic [NUM_CORES-1:0]     core_busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NONCE_W-1:0]       res_nonce,
  output logic [3:0]               res_core,
  output logic                     busy,
  output logic                     exhausted,
  output logic [7:0]               drop_cnt
`ifdef SIA_DISPATCH_HASHCNT_EN
  ,
  output logic [47:0]              hash_cnt
`endif
);

  dispatch_state_t state;
  dispatch_state_t state_nx;

  logic pending;
  logic accept;
  logic in_run;
  logic stop_hit;
  logic all_done;

  logic [NUM_CORES*32-1:0] bases;
  logic [3:0]              win;
  logic [NONCE_W-1:0]      win_nonce;
  logic [4:0]              nfound;
  logic                    push;
  logic                    pop;
  logic                    room;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [4:0]              drop_inc;
  logic [8:0]              drop_sum;

  assign work_ready = (state == ST_IDLE) || (state == ST_RUN);
  assign busy       = (state != ST_IDLE);
  assign core_start = {NUM_CORES{state == ST_DISPATCH}};
  assign core_abort = {NUM_CORES{state == ST_FLUSH}};

  assign accept   = work_valid && work_ready;
  assign in_run   = (state == ST_RUN);
  assign all_done = &core_done;
  assign stop_hit = in_run && (|core_found) && (STOP_ON_FIRST != 0);

  always_comb begin
    bases = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      bases[i*32 +: 32] = slice_base(i, NUM_CORES);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:     if (accept) state_nx = ST_DISPATCH;
      ST_DISPATCH: state_nx = ST_RUN;
      ST_RUN: begin
        if (accept || stop_hit) state_nx = ST_FLUSH;
        else if (all_done)      state_nx = ST_IDLE;
      end
      ST_FLUSH:    state_nx = pending ? ST_DISPATCH : ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      exhausted   <= 1'b0;
      core_work   <= '0;
      core_target <= '0;
      core_nonce0 <= '0;
    end else begin
      state     <= state_nx;
      exhausted <= in_run && !accept && !stop_hit && all_done;
      if (in_run && accept)        pending <= 1'b1;
      else if (state == ST_FLUSH)  pending <= 1'b0;
      if (accept) begin
        core_work   <= work_data;
        core_target <= work_target;
        core_nonce0 <= bases;
      end
    end
  end

  // Lowest index wins the single push slot; the rest count as drops
  always_comb begin
    win       = '0;
    win_nonce = '0;
    nfound    = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        win       = 4'(i);
        win_nonce = core_nonce[i*32 +: 32];
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      nfound = nfound + 5'(core_found[i]);
    end
  end

  assign res_valid = !fifo_empty;
  assign pop       = res_ready && res_valid;
  assign push      = in_run && (|core_found);
  assign room      = !fifo_full || pop;

  always_comb begin
    drop_inc = '0;
    if (push) drop_inc = room ? (nfound - 5'd1) : nfound;
    drop_sum = {1'b0, drop_cnt} + {4'b0, drop_inc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];
  end

  sia_res_fifo #(
    .W     (NONCE_W + 4),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({win, win_nonce}),
    .pop   (pop),
    .dout  ({res_core, res_nonce}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef SIA_DISPATCH_HASHCNT_EN
  logic [4:0] nbusy;

  always_comb begin
    nbusy = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      nbusy = nbusy + 5'(core_busy[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hash_cnt <= '0;
    else        hash_cnt <= hash_cnt + 48'(nbusy);
  end
`else
  logic unused_core_busy;
  assign unused_core_busy = ^core_busy;
`endif

endmodule

// File: tb/tb_sia_dispatch.sv
// Directed bench: dut a stops on first find, dut b keeps searching;
// both share every input so each scenario exercises both policies.
module tb_sia_dispatch;

  logic         clk;
  logic         rst_n;
  logic         work_valid;
  logic [639:0] work_data;
  logic [63:0]  work_target;
  logic [3:0]   core_found;
  logic [127:0] core_nonce;
  logic [3:0]   core_done;
  logic [3:0]   core_busy;
  logic         res_ready;

  logic         a_work_ready, b_work_ready;
  logic [639:0] a_core_work, b_core_work;
  logic [63:0]  a_core_target, b_core_target;
  logic [3:0]   a_core_start, b_core_start;
  logic [127:0] a_core_nonce0, b_core_nonce0;
  logic [3:0]   a_core_abort, b_core_abort;
  logic         a_res_valid, b_res_valid;
  logic [31:0]  a_res_nonce, b_res_nonce;
  logic [3:0]   a_res_core, b_res_core;
  logic         a_busy, b_busy;
  logic         a_exhausted, b_exhausted;
  logic [7:0]   a_drop_cnt, b_drop_cnt;
`ifdef SIA_DISPATCH_HASHCNT_EN
  logic [47:0]  a_hash_cnt, b_hash_cnt;
`endif

  int nchk;
  int npass;

  localparam logic [639:0] W1 = {10{64'h0123_4567_89ab_cdef}};
  localparam logic [639:0] W2 = {10{64'hfeed_beef_5a5a_0f0f}};
  localparam logic [63:0]  T1 = 64'h0000_ffff_0000_0000;
  localparam logic [127:0] BASES =
    {32'hc000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

  sia_dispatch #(.NUM_CORES(4), .RES_DEPTH(4), .STOP_ON_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .work_valid(work_valid), .work_ready(a_work_ready),
    .work_data(work_data), .work_target(work_target),
    .core_work(a_core_work), .core_target(a_core_target),
    .core_start(a_core_start), .core_nonce0(a_core_nonce0),
    .core_abort(a_core_abort), .core_found(core_found),
    .core_nonce(core_nonce), .core_done(core_done),
    .core_busy(core_busy), .res_valid(a_res_valid),
    .res_ready(res_ready), .res_nonce(a_res_nonce),
    .res_core(a_res_core), .busy(a_busy),
    .exhausted(a_exhausted), .drop_cnt(a_drop_cnt)
`ifdef SIA_DISPATCH_HASHCNT_EN
    , .hash_cnt(a_hash_cnt)
`endif
  );

  sia_dispatch #(.NUM_CORES(4), .RES_DEPTH(4), .STOP_ON_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .work_valid(work_valid), .work_ready(b_work_ready),
    .work_data(work_data), .work_target(work_target),
    .core_work(b_core_work), .core_target(b_core_target),
    .core_start(b_core_start), .core_nonce0(b_core_nonce0),
    .core_abort(b_core_abort), .core_found(core_found),
    .core_nonce(core_nonce), .core_done(core_done),
    .core_busy(core_busy), .res_valid(b_res_valid),
    .res_ready(res_ready), .res_nonce(b_res_nonce),
    .res_core(b_res_core), .busy(b_busy),
    .exhausted(b_exhausted), .drop_cnt(b_drop_cnt)
`ifdef SIA_DISPATCH_HASHCNT_EN
    , .hash_cnt(b_hash_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    nchk++; if (a_work_ready !== 1'b1) $display("FAIL reset_work_ready got %0b exp 1", a_work_ready); else npass++;
    nchk++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", a_busy); else npass++;
    nchk++; if (a_core_start !== 4'h0) $display("FAIL reset_start got %h exp 0", a_core_start); else npass++;
    nchk++; if (a_core_abort !== 4'h0) $display("FAIL reset_abort got %h exp 0", a_core_abort); else npass++;
    nchk++; if (b_res_valid !== 1'b0) $display("FAIL reset_res_valid got %0b exp 0", b_res_valid); else npass++;
    nchk++; if (b_drop_cnt !== 8'd0) $display("FAIL reset_drop got %0d exp 0", b_drop_cnt); else npass++;
    nchk++; if (a_core_nonce0 !== 128'd0) $display("FAIL reset_nonce0 got %h exp 0", a_core_nonce0); else npass++;
    nchk++; if (a_core_work !== 640'd0) $display("FAIL reset_core_work nonzero exp 0"); else npass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_dispatch();
    work_data   = W1;
    work_target = T1;
    work_valid  = 1'b1;
    step();
    work_valid  = 1'b0;
    nchk++; if (a_core_start !== 4'hf) $display("FAIL disp_start got %h exp f", a_core_start); else npass++;
    nchk++; if (a_core_nonce0 !== BASES) $display("FAIL disp_nonce0 got %h exp %h", a_core_nonce0, BASES); else npass++;
    nchk++; if (a_core_work !== W1) $display("FAIL disp_core_work got %h exp %h", a_core_work[63:0], W1[63:0]); else npass++;
    nchk++; if (a_core_target !== T1) $display("FAIL disp_target got %h exp %h", a_core_target, T1); else npass++;
    nchk++; if (a_work_ready !== 1'b0) $display("FAIL disp_ready got %0b exp 0", a_work_ready); else npass++;
    step();
    nchk++; if (a_core_start !== 4'h0) $display("FAIL run_start got %h exp 0", a_core_start); else npass++;
    nchk++; if (a_busy !== 1'b1 || a_work_ready !== 1'b1) $display("FAIL run_busy_ready got %0b%0b exp 11", a_busy, a_work_ready); else npass++;
  endtask

  task automatic test_stop_first();
    core_found = 4'b0100;
    core_nonce[2*32 +: 32] = 32'h8000_1234;
    step();
    core_found = 4'b0000;
    nchk++; if (a_res_valid !== 1'b1) $display("FAIL stop_res_valid got %0b exp 1", a_res_valid); else npass++;
    nchk++; if (a_res_nonce !== 32'h8000_1234) $display("FAIL stop_res_nonce got %h exp 80001234", a_res_nonce); else npass++;
    nchk++; if (a_res_core !== 4'd2) $display("FAIL stop_res_core got %0d exp 2", a_res_core); else npass++;
    nchk++; if (a_core_abort !== 4'hf) $display("FAIL stop_abort got %h exp f", a_core_abort); else npass++;
    nchk++; if (b_core_abort !== 4'h0 || b_res_nonce !== 32'h8000_1234) $display("FAIL nostop_find got abort %h nonce %h exp 0 80001234", b_core_abort, b_res_nonce); else npass++;
    step();
    nchk++; if (a_busy !== 1'b0 || a_work_ready !== 1'b1) $display("FAIL stop_idle got busy %0b ready %0b exp 0 1", a_busy, a_work_ready); else npass++;
    nchk++; if (a_core_abort !== 4'h0) $display("FAIL stop_abort_once got %h exp 0", a_core_abort); else npass++;
    nchk++; if (b_busy !== 1'b1) $display("FAIL nostop_busy got %0b exp 1", b_busy); else npass++;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    nchk++; if (a_res_valid !== 1'b0 || b_res_valid !== 1'b0) $display("FAIL stop_pop got %0b%0b exp 00", a_res_valid, b_res_valid); else npass++;
  endtask

  task automatic test_collision();
    core_found = 4'b1010;
    core_nonce[1*32 +: 32] = 32'h1111_0001;
    core_nonce[3*32 +: 32] = 32'h3333_0003;
    step();
    core_found = 4'b0000;
    nchk++; if (b_res_valid !== 1'b1 || b_res_nonce !== 32'h1111_0001) $display("FAIL coll_nonce got %0b %h exp 1 11110001", b_res_valid, b_res_nonce); else npass++;
    nchk++; if (b_res_core !== 4'd1) $display("FAIL coll_core got %0d exp 1", b_res_core); else npass++;
    nchk++; if (b_drop_cnt !== 8'd1) $display("FAIL coll_drop got %0d exp 1", b_drop_cnt); else npass++;
    nchk++; if (a_drop_cnt !== 8'd0 || a_res_valid !== 1'b0) $display("FAIL idle_ignore got drop %0d valid %0b exp 0 0", a_drop_cnt, a_res_valid); else npass++;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [31:0] exp_head [4];
    exp_head = '{32'h101, 32'h102, 32'h103, 32'h105};
    for (int k = 0; k < 5; k++) begin
      core_found = 4'b0001;
      core_nonce[31:0] = 32'h100 + 32'(k);
      step();
    end
    core_found = 4'b0000;
    nchk++; if (b_res_valid !== 1'b1 || b_res_nonce !== 32'h100) $display("FAIL full_head got %0b %h exp 1 100", b_res_valid, b_res_nonce); else npass++;
    nchk++; if (b_drop_cnt !== 8'd2) $display("FAIL full_drop got %0d exp 2", b_drop_cnt); else npass++;
    core_found = 4'b0001;
    core_nonce[31:0] = 32'h105;
    res_ready = 1'b1;
    step();
    core_found = 4'b0000;
    nchk++; if (b_res_nonce !== exp_head[0]) $display("FAIL full_pushpop_head got %h exp %h", b_res_nonce, exp_head[0]); else npass++;
    nchk++; if (b_drop_cnt !== 8'd2) $display("FAIL full_pushpop_drop got %0d exp 2", b_drop_cnt); else npass++;
    for (int k = 1; k < 4; k++) begin
      step();
      nchk++; if (b_res_nonce !== exp_head[k]) $display("FAIL drain_%0d got %h exp %h", k, b_res_nonce, exp_head[k]); else npass++;
    end
    step();
    res_ready = 1'b0;
    nchk++; if (b_res_valid !== 1'b0) $display("FAIL drain_empty got %0b exp 0", b_res_valid); else npass++;
  endtask

  task automatic test_exhaust();
    core_done = 4'hf;
    step();
    core_done = 4'h0;
    nchk++; if (b_exhausted !== 1'b1) $display("FAIL exh_pulse got %0b exp 1", b_exhausted); else npass++;
    nchk++; if (b_busy !== 1'b0 || b_work_ready !== 1'b1) $display("FAIL exh_idle got busy %0b ready %0b exp 0 1", b_busy, b_work_ready); else npass++;
    nchk++; if (b_core_abort !== 4'h0) $display("FAIL exh_abort got %h exp 0", b_core_abort); else npass++;
    nchk++; if (a_exhausted !== 1'b0) $display("FAIL exh_idle_ignore got %0b exp 0", a_exhausted); else npass++;
    step();
    nchk++; if (b_exhausted !== 1'b0) $display("FAIL exh_once got %0b exp 0", b_exhausted); else npass++;
  endtask

  task automatic test_new_work();
    work_data  = W1;
    work_valid = 1'b1;
    step();
    work_valid = 1'b0;
    step();
    work_data  = W2;
    work_valid = 1'b1;
    step();
    work_valid = 1'b0;
    nchk++; if (a_core_abort !== 4'hf || a_core_start !== 4'h0) $display("FAIL nw_abort got abort %h start %h exp f 0", a_core_abort, a_core_start); else npass++;
    nchk++; if (a_work_ready !== 1'b0) $display("FAIL nw_flush_ready got %0b exp 0", a_work_ready); else npass++;
    step();
    nchk++; if (a_core_start !== 4'hf || a_core_abort !== 4'h0) $display("FAIL nw_start got start %h abort %h exp f 0", a_core_start, a_core_abort); else npass++;
    nchk++; if (a_core_work !== W2) $display("FAIL nw_core_work got %h exp %h", a_core_work[63:0], W2[63:0]); else npass++;
    step();
    nchk++; if (a_busy !== 1'b1 || a_core_start !== 4'h0) $display("FAIL nw_run got busy %0b start %h exp 1 0", a_busy, a_core_start); else npass++;
  endtask

  task automatic test_reset_mid();
    core_found = 4'b0001;
    core_nonce[31:0] = 32'h7;
    step();
    core_found = 4'b0000;
    rst_n = 1'b0;
    step();
    nchk++; if (a_busy !== 1'b0 || a_work_ready !== 1'b1) $display("FAIL rmid_state got busy %0b ready %0b exp 0 1", a_busy, a_work_ready); else npass++;
    nchk++; if (a_core_abort !== 4'h0 || b_core_abort !== 4'h0) $display("FAIL rmid_abort got %h %h exp 0 0", a_core_abort, b_core_abort); else npass++;
    nchk++; if (a_core_work !== 640'd0 || a_core_nonce0 !== 128'd0) $display("FAIL rmid_work got nonce0 %h exp 0", a_core_nonce0); else npass++;
    nchk++; if (b_drop_cnt !== 8'd0 || b_res_valid !== 1'b0) $display("FAIL rmid_fifo got drop %0d valid %0b exp 0 0", b_drop_cnt, b_res_valid); else npass++;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    nchk        = 0;
    npass       = 0;
    rst_n       = 1'b0;
    work_valid  = 1'b0;
    work_data   = '0;
    work_target = '0;
    core_found  = '0;
    core_nonce  = '0;
    core_done   = '0;
    core_busy   = 4'b1011;
    res_ready   = 1'b0;
    test_reset();
    test_dispatch();
    test_stop_first();
    test_collision();
    test_fifo_full();
    test_exhaust();
    test_new_work();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
